alu_exec: RTL and testbench



---
 rtl/alu_exec_if.sv | 25 ++
 rtl/alu_exec.sv | 118 +++++++++++
 tb/tb_alu_exec.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Request/response bundle for alu_exec: operation request in, registered result out,
// each side with its own valid/ready handshake.
interface alu_exec_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       alu_control;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;

   modport master (
      output in_valid, alu_control, src_a, src_b, out_ready,
      input  in_ready, out_valid, result, zero
   );

   modport slave (
      input  in_valid, alu_control, src_a, src_b, out_ready,
      output in_ready, out_valid, result, zero
   );
endinterface

// File: rtl/alu_exec.sv
// Sequenced execute unit: single-cycle add/sub/and/or/slt, iterative one-bit-per-cycle
// shifts, registered result and zero flag behind valid/ready handshakes.
module alu_exec #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic       clk,
   input  logic       reset,
   alu_exec_if.slave  bus
);

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpAnd = 3'b010;
   localparam logic [2:0] OpOr  = 3'b011;
   localparam logic [2:0] OpSll = 3'b100;
   localparam logic [2:0] OpSlt = 3'b101;
   localparam logic [2:0] OpSrl = 3'b110;
   localparam logic [2:0] OpSra = 3'b111;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 zero_q, zero_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [SHAMT_W-1:0]   count_q, count_d;
   logic [2:0]           op_q, op_d;
   logic [WIDTH-1:0]     shifted;
   logic [SHAMT_W-1:0]   shamt;
   logic                 slt_bit;

   assign shamt   = bus.src_b[SHAMT_W-1:0];
   assign slt_bit = $signed(bus.src_a) < $signed(bus.src_b);

   // One step of the iterative shifter, selected by the latched opcode.
   always_comb begin
      shifted = acc_q << 1;
      case (op_q)
         OpSrl:   shifted = acc_q >> 1;
         OpSra:   shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
         default: shifted = acc_q << 1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      acc_d    = acc_q;
      count_d  = count_q;
      op_d     = op_q;
      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               op_d    = bus.alu_control;
               state_d = StDone;
               case (bus.alu_control)
                  OpAdd: result_d = bus.src_a + bus.src_b;
                  OpSub: result_d = bus.src_a - bus.src_b;
                  OpAnd: result_d = bus.src_a & bus.src_b;
                  OpOr:  result_d = bus.src_a | bus.src_b;
                  OpSlt: result_d = {{(WIDTH-1){1'b0}}, slt_bit};
                  OpSll, OpSrl, OpSra: begin
                     acc_d   = bus.src_a;
                     count_d = shamt;
                     // A zero shift amount completes immediately, like a non-shift op.
                     if (shamt == '0) begin
                        result_d = bus.src_a;
                     end else begin
                        state_d = StShift;
                     end
                  end
                  default: result_d = result_q;
               endcase
            end
         end
         StShift: begin
            acc_d   = shifted;
            count_d = count_q - SHAMT_W'(1);
            if (count_q == SHAMT_W'(1)) begin
               result_d = shifted;
               state_d  = StDone;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      zero_d = (result_d == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         result_q <= '0;
         zero_q   <= 1'b1;
         acc_q    <= '0;
         count_q  <= '0;
         op_q     <= OpAdd;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
         op_q     <= op_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: reset, arithmetic/logic ops, shifts with latency,
// output backpressure, input changes during a shift, and reset mid-shift.
module tb_alu_exec;
   localparam int unsigned WIDTH = 32;

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpAnd = 3'b010;
   localparam logic [2:0] OpOr  = 3'b011;
   localparam logic [2:0] OpSll = 3'b100;
   localparam logic [2:0] OpSlt = 3'b101;
   localparam logic [2:0] OpSrl = 3'b110;
   localparam logic [2:0] OpSra = 3'b111;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   alu_exec_if #(.WIDTH(WIDTH)) bus ();

   alu_exec #(.WIDTH(WIDTH), .SHAMT_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [2:0]  ar_op  [9] = '{OpAdd, OpAdd, OpSub, OpSub, OpAnd, OpOr, OpSlt, OpSlt, OpSlt};
   logic [31:0] ar_a   [9] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'h0000_F0F0,
                               32'h0000_F000, 32'hFFFF_FFFF, 32'd1, 32'd5};
   logic [31:0] ar_b   [9] = '{32'd1, 32'd1, 32'd5, 32'd1, 32'h0000_0FF0, 32'h0000_000F,
                               32'd1, 32'hFFFF_FFFF, 32'd5};
   logic [31:0] ar_exp [9] = '{32'h8000_0000, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0000_00F0,
                               32'h0000_F00F, 32'd1, 32'd0, 32'd0};

   logic [2:0]  sh_op  [8] = '{OpSll, OpSrl, OpSra, OpSll, OpSrl, OpSra, OpSrl, OpSra};
   logic [31:0] sh_a   [8] = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'h3, 32'h1234_5678,
                               32'hF000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
   logic [31:0] sh_b   [8] = '{32'd31, 32'd4, 32'd4, 32'h25, 32'd0, 32'd31, 32'd31, 32'd8};
   logic [31:0] sh_exp [8] = '{32'h8000_0000, 32'h0800_0000, 32'hF800_0000, 32'h60,
                               32'h1234_5678, 32'hFFFF_FFFF, 32'h1, 32'h007F_FFFF};
   int          sh_lat [8] = '{31, 4, 4, 5, 0, 31, 31, 8};

   // Present a request; returns 1ns after the accepting edge (unit assumed idle).
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.alu_control = op;
      bus.src_a       = a;
      bus.src_b       = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Counts edges until out_valid, bounded by max.
   task automatic wait_out(input int max, output int lat);
      lat = 0;
      while (!bus.out_valid && lat < max) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset           = 1'b1;
      bus.in_valid    = 1'b0;
      bus.out_ready   = 1'b0;
      bus.alu_control = 3'b000;
      bus.src_a       = '0;
      bus.src_b       = '0;
      #3;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
      end
      checks++;
      if (bus.result !== 32'h0) begin
         errors++; $display("FAIL reset_result got %h want 0", bus.result);
      end
      checks++;
      if (bus.zero !== 1'b1) begin
         errors++; $display("FAIL reset_zero got %b want 1", bus.zero);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_arith();
      int lat;
      for (int i = 0; i < 9; i++) begin
         send(ar_op[i], ar_a[i], ar_b[i]);
         wait_out(4, lat);
         checks++;
         if (lat !== 0) begin
            errors++; $display("FAIL arith%0d_latency got %0d want 0", i, lat);
         end
         checks++;
         if (bus.result !== ar_exp[i]) begin
            errors++; $display("FAIL arith%0d_result got %h want %h", i, bus.result, ar_exp[i]);
         end
         checks++;
         if (bus.zero !== (ar_exp[i] == 32'h0)) begin
            errors++; $display("FAIL arith%0d_zero got %b want %b", i, bus.zero, ar_exp[i] == 0);
         end
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL arith%0d_in_ready_busy got %b want 0", i, bus.in_ready);
         end
         take();
         checks++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL arith%0d_release got valid=%b ready=%b want 0/1", i, bus.out_valid,
                     bus.in_ready);
         end
      end
   endtask

   task automatic test_shift();
      int lat;
      for (int i = 0; i < 8; i++) begin
         send(sh_op[i], sh_a[i], sh_b[i]);
         wait_out(40, lat);
         checks++;
         if (lat !== sh_lat[i]) begin
            errors++; $display("FAIL shift%0d_latency got %0d want %0d", i, lat, sh_lat[i]);
         end
         checks++;
         if (bus.result !== sh_exp[i]) begin
            errors++; $display("FAIL shift%0d_result got %h want %h", i, bus.result, sh_exp[i]);
         end
         checks++;
         if (bus.zero !== (sh_exp[i] == 32'h0)) begin
            errors++; $display("FAIL shift%0d_zero got %b want %b", i, bus.zero, sh_exp[i] == 0);
         end
         take();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      send(OpAdd, 32'h10, 32'h20);
      // A competing request held while the result waits must be ignored.
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.alu_control = OpSub;
      bus.src_a       = 32'd9;
      bus.src_b       = 32'd4;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.result !== 32'h30 || bus.zero !== 1'b0 || bus.out_valid !== 1'b1 ||
             bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall%0d got res=%h z=%b v=%b r=%b want 30/0/1/0", i, bus.result,
                     bus.zero, bus.out_valid, bus.in_ready);
         end
      end
      // Consume while the request is still pending: it must not be taken on this edge.
      take();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL no_overlap got v=%b r=%b want 0/1", bus.out_valid, bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      wait_out(4, lat);
      checks++;
      if (lat !== 0 || bus.result !== 32'd5) begin
         errors++;
         $display("FAIL next_accept got lat=%0d res=%h want 0/00000005", lat, bus.result);
      end
      take();
   endtask

   task automatic test_input_change();
      int lat;
      send(OpSrl, 32'hFF, 32'd3);
      bus.src_a       = 32'h0;
      bus.src_b       = 32'h0;
      bus.alu_control = OpAdd;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL shift_busy_in_ready got %b want 0", bus.in_ready);
      end
      wait_out(40, lat);
      checks++;
      if (lat !== 3 || bus.result !== 32'h1F) begin
         errors++;
         $display("FAIL input_change got lat=%0d res=%h want 3/0000001f", lat, bus.result);
      end
      take();
   endtask

   task automatic test_reset_mid_shift();
      int lat;
      send(OpSll, 32'h1, 32'd20);
      repeat (7) @(posedge clk);
      #2;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.result !== 32'h1F) begin
         errors++;
         $display("FAIL pre_reset got r=%b res=%h want 0/0000001f", bus.in_ready, bus.result);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 32'h0 ||
          bus.zero !== 1'b1) begin
         errors++;
         $display("FAIL async_reset got v=%b r=%b res=%h z=%b want 0/1/0/1", bus.out_valid,
                  bus.in_ready, bus.result, bus.zero);
      end
      @(negedge clk);
      reset = 1'b0;
      send(OpAdd, 32'd3, 32'd4);
      wait_out(4, lat);
      checks++;
      if (lat !== 0 || bus.result !== 32'd7 || bus.zero !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_add got lat=%0d res=%h z=%b want 0/00000007/0", lat,
                  bus.result, bus.zero);
      end
      take();
   endtask

   initial begin
      test_reset();
      test_arith();
      test_shift();
      test_backpressure();
      test_input_change();
      test_reset_mid_shift();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
